// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: loads a WIDTH-bit word and shifts it out one bit per
// enabled cycle, with frame markers and back-to-back reload on the last bit.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    // state | meaning
    // IDLE  | no word held, dout driven 0, ready for a load
    // SHIFT | word in shift register, dout presents bit cnt
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    cnt;
    logic             last_presented;
    logic             accept;

    // A held bit (dout_valid=0 after a pause) is not yet delivered, so the last
    // bit only frees the register once it is shown valid and shift_en is high.
    assign last_presented = (state == SHIFT) && dout_valid && (cnt == LAST);
    assign load_ready     = !rst && ((state == IDLE) || (last_presented && shift_en));
    assign accept         = load_valid && load_ready;

    always_comb begin
        shreg_next = shreg;
        if (MSB_FIRST) shreg_next = shreg << 1;
        else           shreg_next = shreg >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
        end else if (accept) begin
            state       <= SHIFT;
            shreg       <= load_data;
            cnt         <= '0;
            dout        <= MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
            dout_valid  <= 1'b1;
            frame_start <= 1'b1;
            frame_end   <= 1'b0;
            busy        <= 1'b1;
        end else if (state == SHIFT) begin
            if (!shift_en) begin
                dout_valid  <= 1'b0;
                frame_start <= 1'b0;
                frame_end   <= 1'b0;
            end else if (!dout_valid) begin
                // resume after pause: re-present the held bit once
                dout_valid  <= 1'b1;
                frame_start <= (cnt == '0);
                frame_end   <= (cnt == LAST);
            end else if (cnt == LAST) begin
                state       <= IDLE;
                shreg       <= '0;
                cnt         <= '0;
                dout        <= 1'b0;
                dout_valid  <= 1'b0;
                frame_start <= 1'b0;
                frame_end   <= 1'b0;
                busy        <= 1'b0;
            end else begin
                shreg       <= shreg_next;
                cnt         <= cnt + CW'(1);
                dout        <= MSB_FIRST ? shreg_next[WIDTH-1] : shreg_next[0];
                dout_valid  <= 1'b1;
                frame_start <= 1'b0;
                frame_end   <= ((cnt + CW'(1)) == LAST);
            end
        end else begin
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: per-cycle vector table plus hand-written
// sequences for pause, mid-word reset and LSB-first ordering.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       shift_en = 1'b1;

    logic load_ready, dout, dout_valid, frame_start, frame_end, busy;
    logic l_ready, l_dout, l_valid, l_fs, l_fe, l_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .shift_en(shift_en), .dout(dout),
        .dout_valid(dout_valid), .frame_start(frame_start), .frame_end(frame_end),
        .busy(busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(l_ready), .shift_en(shift_en), .dout(l_dout),
        .dout_valid(l_valid), .frame_start(l_fs), .frame_end(l_fe),
        .busy(l_busy)
    );

    // exp = {dout, dout_valid, frame_start, frame_end, busy, load_ready}
    typedef struct {
        logic       rst;
        logic       lv;
        logic [7:0] data;
        logic       se;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic void add(input logic r, input logic lv, input logic [7:0] d,
                                input logic se, input logic [5:0] e);
        vec_t v;
        v.rst = r; v.lv = lv; v.data = d; v.se = se; v.exp = e;
        vecs.push_back(v);
    endfunction

    // One word of MSB-first output; lv_hold keeps load_valid high with next_data,
    // pulse_idx raises load_valid with next_data only during that bit.
    function automatic void push_word(input logic [7:0] w, input logic lv_hold,
                                      input logic [7:0] next_data, input int pulse_idx);
        logic lv;
        for (int i = 0; i < 8; i++) begin
            lv = lv_hold || (i == pulse_idx);
            add(1'b0, lv, lv ? next_data : 8'h00, 1'b1,
                {w[7-i], 1'b1, (i == 0), (i == 7), 1'b1, (i == 7)});
        end
    endfunction

    initial begin
        logic [5:0] got;
        logic [7:0] lsb_word;
        int vcount, delivered, low_cnt, pause_left, cyc;
        logic paused_done, dout_ok;

        add(1'b1, 1'b0, 8'h00, 1'b1, 6'b000000);
        add(1'b0, 1'b1, 8'hA0, 1'b1, 6'b000001);
        push_word(8'hA0, 1'b0, 8'h00, -1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 6'b000001);
        add(1'b0, 1'b1, 8'hA5, 1'b1, 6'b000001);
        push_word(8'hA5, 1'b1, 8'h3C, -1);
        push_word(8'h3C, 1'b0, 8'h00, -1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 6'b000001);
        add(1'b0, 1'b1, 8'h00, 1'b1, 6'b000001);
        push_word(8'h00, 1'b0, 8'hFF, 1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 6'b000001);
        add(1'b1, 1'b1, 8'hFF, 1'b1, 6'b000000);
        add(1'b0, 1'b0, 8'h00, 1'b1, 6'b000001);
        add(1'b0, 1'b0, 8'h00, 1'b1, 6'b000001);

        @(negedge clk);
        foreach (vecs[k]) begin
            @(negedge clk);
            rst = vecs[k].rst; load_valid = vecs[k].lv;
            load_data = vecs[k].data; shift_en = vecs[k].se;
            #1;
            got = {dout, dout_valid, frame_start, frame_end, busy, load_ready};
            check($sformatf("vec%0d", k), 32'(got), 32'(vecs[k].exp));
        end

        // LSB-first ordering of 8'h05
        @(negedge clk);
        rst = 1'b0; load_valid = 1'b1; load_data = 8'h05; shift_en = 1'b1;
        #1 check("lsb_ready", 32'(l_ready), 32'd1);
        lsb_word = 8'h05;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            #1;
            check($sformatf("lsb_bit%0d", i), 32'({l_dout, l_valid, l_fs, l_fe, l_busy}),
                  32'({lsb_word[i], 1'b1, (i == 0), (i == 7), 1'b1}));
        end
        @(negedge clk);
        #1 check("lsb_idle", 32'({l_dout, l_valid, l_busy}), 32'd0);

        // reset while the 4th bit is presented
        @(negedge clk);
        load_valid = 1'b1; load_data = 8'hA5;
        vcount = 0;
        for (int i = 0; i < 20 && vcount < 4; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            #1 if (dout_valid) vcount++;
        end
        check("rst_reach_bit4", 32'(vcount), 32'd4);
        rst = 1'b1;
        #1 check("rst_ready_low", 32'(load_ready), 32'd0);
        @(negedge clk);
        #1 check("rst_outputs", 32'({dout, dout_valid, frame_start, frame_end, busy}), 32'd0);
        rst = 1'b0;
        #1 check("rst_ready_after", 32'(load_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check($sformatf("rst_no_resume%0d", i), 32'({dout_valid, busy}), 32'd0);
        end

        // 8'hFF with a two-cycle shift_en pause on the 4th bit
        @(negedge clk);
        load_valid = 1'b1; load_data = 8'hFF; shift_en = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        #1;
        delivered = 0; low_cnt = 0; pause_left = 0; paused_done = 1'b0; dout_ok = 1'b1;
        for (cyc = 0; cyc < 30; cyc++) begin
            if (!busy) break;
            if (!paused_done && dout_valid && delivered == 3) begin
                pause_left = 2;
                paused_done = 1'b1;
            end
            shift_en = (pause_left == 0);
            if (pause_left > 0) pause_left--;
            if (!dout_valid) low_cnt++;
            if (dout_valid && shift_en) delivered++;
            if (dout !== 1'b1) dout_ok = 1'b0;
            @(negedge clk);
            #1;
        end
        shift_en = 1'b1;
        check("pause_finished", 32'(busy), 32'd0);
        check("pause_delivered", 32'(delivered), 32'd8);
        check("pause_low_cycles", 32'(low_cnt), 32'd2);
        check("pause_dout_held", 32'(dout_ok), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: number of bits per loaded word, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 load_valid  input  1  upstream word available on load_data.
REQ-007 load_data  input  WIDTH  parallel word to serialize.
REQ-008 load_ready  output  1  block accepts load_data on this edge.
REQ-009 shift_en  input  1  1 = advance one bit per cycle; 0 = pause.
REQ-010 dout  output  1  serial bit, fed to the downstream sequence detector's din.
REQ-011 dout_valid  output  1  dout carries a live bit this cycle.
REQ-012 frame_start  output  1  pulse with the first bit of a word.
REQ-013 frame_end  output  1  pulse with the last bit of a word.
REQ-014 busy  output  1  high while in SHIFT state.

Function
REQ-015 States SHALL be IDLE and SHIFT; the state, shift register, bit counter and all outputs except load_ready SHALL be registered.
REQ-016 load_ready SHALL equal !rst && (IDLE || (SHIFT && last bit presented && shift_en)).
REQ-017 A word SHALL be accepted on a rising edge where load_valid && load_ready; otherwise load_data SHALL be ignored.
REQ-018 On acceptance, the cycle after the edge SHALL present the first bit on dout with dout_valid=1, frame_start=1, busy=1 (latency 1 cycle).
REQ-019 With shift_en=1, each subsequent edge SHALL present the next bit; a word SHALL occupy exactly WIDTH valid cycles.
REQ-020 frame_end SHALL be 1 only during the cycle dout presents the last bit; frame_start and frame_end both single-cycle per word.
REQ-021 With shift_en=0 in SHIFT, state, counter and dout SHALL hold, dout_valid, frame_start and frame_end SHALL be 0 at the following cycle, and resume on the edge after shift_en returns to 1 with the held bit re-presented once as valid.
REQ-022 Back-to-back: acceptance on the last-bit edge SHALL make the next word's first bit follow immediately with no invalid gap.
REQ-023 After the last bit with no new acceptance, state SHALL return to IDLE: dout=0, dout_valid=0, busy=0.
REQ-024 In IDLE dout SHALL be 0 so the downstream detector sees idle zeros.
REQ-025 Bit counter SHALL be ceil(log2(WIDTH)) bits wide, count 0..WIDTH-1, never wrap silently past WIDTH-1.
REQ-026 load_valid while SHIFT and not at last bit SHALL have no effect; load_ready=0 there.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, shift register 0, counter 0, dout=0, dout_valid=0, frame_start=0, frame_end=0, busy=0, overriding any concurrent load or shift.
REQ-028 load_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.
REQ-029 Reset mid-word SHALL discard remaining bits; no partial word resumes.

Verification
REQ-030 Load 8'b1010_0000, MSB_FIRST=1, shift_en=1 -> dout 1,0,1,0,0,0,0,0 over 8 valid cycles; frame_start cycle 1, frame_end cycle 8; then busy=0.
REQ-031 load_valid held, words 8'hA5 then 8'h3C -> 16 contiguous dout_valid cycles, dout 10100101 00111100, load_ready high only on the edges of acceptance.
REQ-032 Word 8'hFF, shift_en=0 for 2 cycles after 3rd bit -> dout_valid low 2 cycles, dout held 1, total 8 valid bits delivered.
REQ-033 rst=1 while 4th bit presented -> next cycle dout=0, dout_valid=0, busy=0, load_ready=1 after rst drops.
REQ-034 MSB_FIRST=0, load 8'h05 -> dout 1,0,1,0,0,0,0,0.
REQ-035 load_valid pulsed with 8'hFF during 2nd bit of 8'h00 -> ignored; only 8 zero bits output, then IDLE.
